// File: rtl/sample_dispatch_scheduler_if.sv
// Bundles the byte-stream input, detector handshake and pad outputs of the
// sample dispatch scheduler into one interface.
interface sample_dispatch_scheduler_if #(
  parameter int SEL_WIDTH  = 2,
  parameter int DATA_WIDTH = 16
);
  logic [SEL_WIDTH-1:0]  unit_sel;
  logic                  byte_valid;
  logic [7:0]            byte_in;
  logic                  proc_start;
  logic [SEL_WIDTH-1:0]  proc_unit;
  logic [DATA_WIDTH-1:0] proc_sample;
  logic                  proc_done;
  logic                  proc_spike;
  logic [1:0]            proc_event;
  logic                  spike_out;
  logic [1:0]            event_out;
  logic                  busy;
  logic                  overrun;
  logic                  timeout_err;
  logic                  assembly_err;

  modport slave (
    input  unit_sel, byte_valid, byte_in, proc_done, proc_spike, proc_event,
    output proc_start, proc_unit, proc_sample, spike_out, event_out,
           busy, overrun, timeout_err, assembly_err
  );

  modport master (
    output unit_sel, byte_valid, byte_in, proc_done, proc_spike, proc_event,
    input  proc_start, proc_unit, proc_sample, spike_out, event_out,
           busy, overrun, timeout_err, assembly_err
  );
endinterface

// File: rtl/sample_dispatch_scheduler.sv
// Assembles MSB-first byte pairs into per-unit samples and shares one detector
// across units with round-robin issue and a start/done handshake.
module sample_dispatch_scheduler #(
  parameter int NUM_UNITS  = 2,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic clk,
  input  logic rst,
  sample_dispatch_scheduler_if.slave bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  phase_q, phase_d;  // 1: high byte held, expecting low byte
  logic [7:0]            hi_q, hi_d;
  logic [SEL_WIDTH-1:0]  hi_unit_q, hi_unit_d;
  logic [DATA_WIDTH-1:0] slot_q [NUM_UNITS];
  logic [DATA_WIDTH-1:0] slot_d [NUM_UNITS];
  logic [NUM_UNITS-1:0]  pending_q, pending_d;
  logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]            tmo_cnt_q, tmo_cnt_d;
  logic                  proc_start_q, proc_start_d;
  logic [SEL_WIDTH-1:0]  proc_unit_q, proc_unit_d;
  logic [DATA_WIDTH-1:0] proc_sample_q, proc_sample_d;
  logic [NUM_UNITS-1:0]  spike_q, spike_d;
  logic [1:0]            event_q [NUM_UNITS];
  logic [1:0]            event_d [NUM_UNITS];
  logic                  overrun_q, overrun_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  assembly_err_q, assembly_err_d;

  logic                  found;
  logic [SEL_WIDTH-1:0]  pick;
  logic [SEL_WIDTH-1:0]  next_ptr;
  logic                  in_range;
  logic                  spike_mux;
  logic [1:0]            event_mux;

  // Round-robin: first pending unit at or above rr_ptr, else first below it.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < NUM_UNITS; j++) begin
      if (!found && pending_q[j] && (j >= int'(rr_ptr_q))) begin
        found = 1'b1;
        pick  = SEL_WIDTH'(j);
      end
    end
    for (int j = 0; j < NUM_UNITS; j++) begin
      if (!found && pending_q[j] && (j < int'(rr_ptr_q))) begin
        found = 1'b1;
        pick  = SEL_WIDTH'(j);
      end
    end
  end

  assign next_ptr = (proc_unit_q == SEL_WIDTH'(NUM_UNITS - 1)) ? '0
                                                                : proc_unit_q + SEL_WIDTH'(1);
  assign in_range = int'(bus.unit_sel) < NUM_UNITS;

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    hi_d           = hi_q;
    hi_unit_d      = hi_unit_q;
    slot_d         = slot_q;
    pending_d      = pending_q;
    rr_ptr_d       = rr_ptr_q;
    tmo_cnt_d      = tmo_cnt_q;
    proc_start_d   = 1'b0;
    proc_unit_d    = proc_unit_q;
    proc_sample_d  = proc_sample_q;
    spike_d        = spike_q;
    event_d        = event_q;
    overrun_d      = overrun_q;
    timeout_err_d  = timeout_err_q;
    assembly_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          proc_start_d = 1'b1;
          proc_unit_d  = pick;
          for (int j = 0; j < NUM_UNITS; j++) begin
            if (pick == SEL_WIDTH'(j)) begin
              proc_sample_d = slot_q[j];
              pending_d[j]  = 1'b0;
            end
          end
          tmo_cnt_d = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.proc_done) begin
          for (int j = 0; j < NUM_UNITS; j++) begin
            if (proc_unit_q == SEL_WIDTH'(j)) begin
              spike_d[j] = bus.proc_spike;
              event_d[j] = bus.proc_event;
            end
          end
          rr_ptr_d = next_ptr;
          state_d  = S_IDLE;
        end else if (tmo_cnt_q == 4'(TIMEOUT - 1)) begin
          for (int j = 0; j < NUM_UNITS; j++) begin
            if (proc_unit_q == SEL_WIDTH'(j)) begin
              spike_d[j] = 1'b0;
              event_d[j] = 2'b00;
            end
          end
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Evaluated after the issue clear so a same-edge completion stays pending
    // and is not mistaken for an overwrite.
    if (bus.byte_valid && in_range) begin
      if (!phase_q) begin
        hi_d      = bus.byte_in;
        hi_unit_d = bus.unit_sel;
        phase_d   = 1'b1;
      end else if (hi_unit_q == bus.unit_sel) begin
        for (int j = 0; j < NUM_UNITS; j++) begin
          if (bus.unit_sel == SEL_WIDTH'(j)) begin
            if (pending_d[j]) overrun_d = 1'b1;
            slot_d[j]    = {hi_q, bus.byte_in};
            pending_d[j] = 1'b1;
          end
        end
        phase_d = 1'b0;
      end else begin
        assembly_err_d = 1'b1;
        hi_d           = bus.byte_in;
        hi_unit_d      = bus.unit_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      phase_q        <= 1'b0;
      hi_q           <= '0;
      hi_unit_q      <= '0;
      for (int j = 0; j < NUM_UNITS; j++) begin
        slot_q[j]  <= '0;
        event_q[j] <= '0;
      end
      pending_q      <= '0;
      rr_ptr_q       <= '0;
      tmo_cnt_q      <= '0;
      proc_start_q   <= 1'b0;
      proc_unit_q    <= '0;
      proc_sample_q  <= '0;
      spike_q        <= '0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
      assembly_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      hi_q           <= hi_d;
      hi_unit_q      <= hi_unit_d;
      slot_q         <= slot_d;
      event_q        <= event_d;
      pending_q      <= pending_d;
      rr_ptr_q       <= rr_ptr_d;
      tmo_cnt_q      <= tmo_cnt_d;
      proc_start_q   <= proc_start_d;
      proc_unit_q    <= proc_unit_d;
      proc_sample_q  <= proc_sample_d;
      spike_q        <= spike_d;
      overrun_q      <= overrun_d;
      timeout_err_q  <= timeout_err_d;
      assembly_err_q <= assembly_err_d;
    end
  end

  always_comb begin
    spike_mux = 1'b0;
    event_mux = 2'b00;
    for (int j = 0; j < NUM_UNITS; j++) begin
      if (bus.unit_sel == SEL_WIDTH'(j)) begin
        spike_mux = spike_q[j];
        event_mux = event_q[j];
      end
    end
  end

  assign bus.proc_start   = proc_start_q;
  assign bus.proc_unit    = proc_unit_q;
  assign bus.proc_sample  = proc_sample_q;
  assign bus.spike_out    = spike_mux;
  assign bus.event_out    = event_mux;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.overrun      = overrun_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.assembly_err = assembly_err_q;

endmodule

// File: tb/tb_sample_dispatch_scheduler.sv
// Scoreboard bench: completed samples are queued as expected issues and
// matched against every proc_start the scheduler produces.
module tb_sample_dispatch_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_dispatch_scheduler_if #(.SEL_WIDTH(2), .DATA_WIDTH(16)) bus ();

  sample_dispatch_scheduler #(
    .NUM_UNITS(2), .DATA_WIDTH(16), .SEL_WIDTH(2), .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]  unit;
    logic [15:0] sample;
  } exp_t;

  exp_t sb_q[$];
  int   checks      = 0;
  int   errors      = 0;
  logic exp_overrun = 1'b0;
  logic prev_start  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // A completed sample replaces a not-yet-issued entry of the same unit.
  task automatic push_exp(input logic [1:0] u, input logic [15:0] s);
    bit hit = 0;
    foreach (sb_q[i]) begin
      if (sb_q[i].unit == u) begin
        sb_q[i].sample = s;
        hit = 1;
        exp_overrun = 1'b1;
      end
    end
    if (!hit) sb_q.push_back('{unit: u, sample: s});
  endtask

  task automatic send_byte(input logic [1:0] u, input logic [7:0] b);
    bus.unit_sel   = u;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [1:0] u, input logic [7:0] hi, input logic [7:0] lo);
    send_byte(u, hi);
    send_byte(u, lo);
    push_exp(u, {hi, lo});
  endtask

  task automatic wait_start(input string tag, output int cycles);
    cycles = 0;
    while (!bus.proc_start && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_start_seen"}, bus.proc_start, 1);
  endtask

  task automatic give_done(input logic sp, input logic [1:0] ev, input int dly);
    repeat (dly) @(negedge clk);
    bus.proc_done  = 1'b1;
    bus.proc_spike = sp;
    bus.proc_event = ev;
    @(negedge clk);
    bus.proc_done  = 1'b0;
    bus.proc_spike = 1'b0;
    bus.proc_event = 2'b00;
  endtask

  task automatic check_out(input string tag, input logic [1:0] u, input logic sp, input logic [1:0] ev);
    bus.unit_sel = u;
    #1;
    check({tag, "_spike"}, bus.spike_out, sp);
    check({tag, "_event"}, bus.event_out, ev);
  endtask

  // Monitor: each issue must match the head of the scoreboard and last one cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (bus.proc_start) begin
        exp_t e;
        check("start_width", prev_start, 0);
        check("start_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("issue_unit", bus.proc_unit, e.unit);
          check("issue_sample", bus.proc_sample, e.sample);
          $display("issue unit=%0d sample=%04h (expected unit=%0d sample=%04h)",
                   bus.proc_unit, bus.proc_sample, e.unit, e.sample);
        end
      end
      prev_start = bus.proc_start;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_proc_start"}, bus.proc_start, 0);
    check({tag, "_proc_unit"}, bus.proc_unit, 0);
    check({tag, "_proc_sample"}, bus.proc_sample, 0);
    check({tag, "_overrun"}, bus.overrun, 0);
    check({tag, "_timeout_err"}, bus.timeout_err, 0);
    check({tag, "_assembly_err"}, bus.assembly_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.unit_sel   = '0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = '0;
    bus.proc_done  = 1'b0;
    bus.proc_spike = 1'b0;
    bus.proc_event = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_all_zero("reset");
    check_out("reset_u0", 2'd0, 1'b0, 2'd0);
    check_out("reset_u1", 2'd1, 1'b0, 2'd0);
    @(negedge clk);

    // Basic issue, latency and result storage
    send_sample(2'd0, 8'h12, 8'h34);
    check("lat_no_start_yet", bus.proc_start, 0);
    wait_start("basic", n);
    check("basic_latency", n, 1);
    check("basic_busy", bus.busy, 1);
    give_done(1'b1, 2'd2, 2);
    check("basic_idle", bus.busy, 0);
    check_out("basic_u0", 2'd0, 1'b1, 2'd2);
    check_out("basic_u1", 2'd1, 1'b0, 2'd0);
    check_out("oor_u3", 2'd3, 1'b0, 2'd0);
    @(negedge clk);

    // Unit switch mid-sample discards the held MSB
    send_byte(2'd0, 8'hAA);
    send_byte(2'd1, 8'hBB);
    check("asm_err_pulse", bus.assembly_err, 1);
    send_byte(2'd1, 8'hCC);
    check("asm_err_clear", bus.assembly_err, 0);
    push_exp(2'd1, 16'hBBCC);
    wait_start("asm", n);
    give_done(1'b0, 2'd1, 1);
    repeat (4) @(negedge clk);
    check("asm_no_extra_issue", bus.busy, 0);

    // Round-robin ordering with both units pending
    send_sample(2'd0, 8'h0A, 8'h0B);
    wait_start("rr_a", n);
    give_done(1'b0, 2'd1, 0);
    send_sample(2'd1, 8'h11, 8'h11);
    wait_start("rr_b", n);
    send_sample(2'd0, 8'h22, 8'h22);
    send_sample(2'd1, 8'h33, 8'h33);
    check("rr_overrun", bus.overrun, exp_overrun);
    give_done(1'b1, 2'd3, 1);
    wait_start("rr_c", n);
    send_sample(2'd0, 8'h44, 8'h44);
    give_done(1'b0, 2'd0, 0);
    wait_start("rr_d", n);
    give_done(1'b1, 2'd1, 0);
    wait_start("rr_e", n);
    give_done(1'b0, 2'd2, 0);
    check_out("rr_u0", 2'd0, 1'b0, 2'd2);
    check_out("rr_u1", 2'd1, 1'b1, 2'd1);
    @(negedge clk);

    // Overwrite of a pending sample
    send_sample(2'd1, 8'h55, 8'h55);
    wait_start("ovr_a", n);
    send_sample(2'd0, 8'h00, 8'h01);
    send_sample(2'd0, 8'h00, 8'h02);
    check("ovr_flag", bus.overrun, exp_overrun);
    give_done(1'b0, 2'd0, 1);
    wait_start("ovr_b", n);
    give_done(1'b1, 2'd3, 0);
    check_out("ovr_u0", 2'd0, 1'b1, 2'd3);
    @(negedge clk);

    // Detector never answers
    send_sample(2'd0, 8'h77, 8'h77);
    wait_start("tmo", n);
    repeat (14) @(negedge clk);
    check("tmo_still_busy", bus.busy, 1);
    check("tmo_not_yet", bus.timeout_err, 0);
    @(negedge clk);
    check("tmo_idle", bus.busy, 0);
    check("tmo_flag", bus.timeout_err, 1);
    check_out("tmo_u0", 2'd0, 1'b0, 2'd0);
    @(negedge clk);

    // Reset while waiting; the late done must be ignored
    send_sample(2'd1, 8'h99, 8'h99);
    wait_start("rst", n);
    send_sample(2'd0, 8'h66, 8'h66);
    rst = 1'b1;
    sb_q.delete();
    exp_overrun = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_wait");
    give_done(1'b1, 2'd3, 0);
    repeat (5) @(negedge clk);
    check("rst_busy_after", bus.busy, 0);
    check_out("rst_u1", 2'd1, 1'b0, 2'd0);
    check_out("rst_u0", 2'd0, 1'b0, 2'd0);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_dispatch_scheduler.md
Name: sample_dispatch_scheduler

Overview:
Front-end controller for the spike-detection array. It assembles the MSB-first byte stream (unit select plus byte strobe) into 16-bit samples and holds one pending sample per unit. It time-multiplexes a single shared detector datapath across NUM_UNITS using round-robin scheduling with a start/done handshake. Per-unit spike/event results are stored, and the result for the currently selected unit is presented to the pad outputs.

Parameters:
NUM_UNITS, 2, number of logical channels (1..4)
DATA_WIDTH, 16, sample width; fixed at two bytes
SEL_WIDTH, 2, width of the unit select / unit index
TIMEOUT, 15, maximum WAIT cycles before a forced completion (4-bit counter)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
unit_sel  in  SEL_WIDTH  channel for incoming bytes and for the output mux
byte_valid  in  1  byte strobe; one byte is taken per cycle high
byte_in  in  8  sample byte, MSB first
proc_start  out  1  one-cycle start pulse to the shared detector
proc_unit  out  SEL_WIDTH  unit being processed; held stable until done
proc_sample  out  DATA_WIDTH  sample being processed; held stable until done
proc_done  in  1  detector completion; sampled only in WAIT
proc_spike  in  1  detector spike result, valid with proc_done
proc_event  in  2  detector event class, valid with proc_done
spike_out  out  1  stored spike bit of unit_sel
event_out  out  2  stored event class of unit_sel
busy  out  1  high when the FSM is not in IDLE
overrun  out  1  sticky; a pending sample was overwritten
timeout_err  out  1  sticky; a WAIT timed out
assembly_err  out  1  one-cycle pulse; a partial sample was discarded

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - outputs: proc_start=0, proc_unit=0, proc_sample=0, busy=0, overrun=0, timeout_err=0, assembly_err=0;
  - internal: all result regs=0, pending=0, byte phase=MSB, rr_ptr=0, FSM=IDLE.
  - Reset mid-handshake abandons the operation. A later proc_done while in IDLE is ignored.
- Assembler:
  - byte_valid with unit_sel >= NUM_UNITS: byte ignored; phase unchanged.
  - Phase MSB: latch byte_in as the high byte and latch unit_sel; phase becomes LSB.
  - Phase LSB, same unit: form {hi, byte_in}, write the unit's slot, set pending[u], phase becomes MSB.
  - Phase LSB, different unit: discard the held MSB, pulse assembly_err, and treat the byte as the MSB for the new unit.
  - Completing a sample on a unit whose pending bit is already set: the slot is overwritten and overrun is set.
- Scheduler FSM: IDLE -> WAIT -> IDLE.
  - IDLE: if any pending bit is set, select the first pending unit at or after rr_ptr, wrapping modulo NUM_UNITS.
  - At that edge: register proc_start=1 (for exactly one cycle), proc_unit, and proc_sample; clear pending[u]; clear the timeout counter; go to WAIT.
  - Latency: proc_start goes high in the cycle after the LSB strobe's edge when the FSM is IDLE and no other unit is pending.
  - WAIT: count cycles.
    - On proc_done: store proc_spike/proc_event in the result regs of proc_unit, set rr_ptr=proc_unit+1 (wrapping), go to IDLE.
    - If the counter reaches TIMEOUT without done: store spike=0, event=0, set timeout_err, advance rr_ptr, go to IDLE.
  - The minimum inter-issue gap is one IDLE cycle. proc_done in the proc_start cycle counts as done (WAIT is entered at that edge).
- Simultaneous events:
  - LSB completion for unit u on the same edge that u is issued: the set wins. The new sample stays pending and overrun is not flagged.
  - byte_valid during WAIT is accepted normally.
- Outputs: spike_out/event_out are a combinational mux of the result regs by unit_sel. Out-of-range unit_sel gives 0.

Test Plan:
- Reset then unit 0 bytes 0x12, 0x34: proc_start high one cycle later with proc_unit=0, proc_sample=0x1234. Done with spike=1, event=2 gives spike_out=1 and event_out=2 for unit_sel=0, and 0 for unit_sel=1.
- Units 0 and 1 both complete while WAIT is held by unit 1 with rr_ptr=1: next issue order is unit 0 then unit 1. Verify round-robin and that no unit is starved.
- Unit 0 sends 0xAA, then unit 1 sends 0xBB, 0xCC: assembly_err pulses once. Unit 1 sample=0xBBCC; unit 0 receives nothing.
- Two complete unit-0 samples (0x0001, 0x0002) while busy with unit 1: overrun=1, and unit 0 is later issued with 0x0002.
- Detector never asserts done: after 15 WAIT cycles timeout_err=1, result regs 0, FSM back to IDLE with busy=0.
- Assert rst in WAIT, then proc_done after release: all outputs 0, no result written, no proc_start.
